dmx512_tx: RTL and testbench

DMX512 frame transmitter driving the board's `TX` pin from the 12.09 MHz `clk_In` domain. It sits between the ClockGen frame-rate output (30/40 Hz) and the TX pin. On each frame request it emits BREAK, then MAB, then a start code, then `NUM_SLOTS` data slots fetched from an external slot buffer. Bit timing comes from an internal divider, so it needs no second clock.

---
 rtl/dmx_pkg.sv | 24 ++
 rtl/dmx_bit_timer.sv | 41 ++++
 rtl/dmx512_tx.sv | 197 +++++++++++++++++++
 tb/tb_dmx512_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmx_pkg
//  Purpose  : Shared types and constants for the DMX512 transmitter.
//             State enum, slot framing length, slot count limit and the
//             default start code.
//  Revision : 1.0 - initial release
// ============================================================================
package dmx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAB   = 2'd2,
        SLOT  = 2'd3
    } dmx_state_t;

    // start bit + 8 data bits + 2 stop bits
    localparam int         DMX_SLOT_BITS  = 11;
    localparam int         DMX_MAX_SLOTS  = 512;
    localparam logic [7:0] DMX_START_CODE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/dmx_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : dmx_bit_timer
//  Purpose  : DMX bit-period divider. Counts 0..CLKS_PER_BIT-1 and emits a
//             one-cycle bit_tick in the last cycle of every bit period.
//  Ports    : clk       - system clock
//             rst_n     - synchronous active-low reset
//             restart   - hold the divider at 0 (bit period restarts)
//             bit_tick  - high in the final cycle of a bit period
//  Revision : 1.0 - initial release
// ============================================================================
module dmx_bit_timer #(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_tick
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Derived from the count only, so the FSM can use it to pick the next
    // state without forming a loop back through restart.
    assign bit_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmx512_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dmx512_tx
//  Purpose  : DMX512 frame transmitter. On a rising edge of frame_req_In it
//             sends BREAK, MAB, the start code slot and NUM_SLOTS data slots
//             fetched from an external slot buffer.
//  Ports    : clk_In         - system clock (12.09 MHz)
//             rst_n          - synchronous active-low reset
//             frame_req_In   - frame request level; rising edge starts a frame
//             rd_en_Out      - slot buffer read strobe (one cycle)
//             rd_addr_Out    - slot buffer address
//             rd_data_In     - slot buffer data, valid the cycle after rd_en
//             TX             - DMX serial line, idle/mark = 1
//             busy_Out       - high while a frame is in progress
//             frame_done_Out - one-cycle pulse after the final stop bit
//  Revision : 1.0 - initial release
// ============================================================================
module dmx512_tx
    import dmx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 48,
    parameter int         BREAK_BITS   = 25,
    parameter int         MAB_BITS     = 3,
    parameter int         NUM_SLOTS    = 512,
    parameter logic [7:0] START_CODE   = DMX_START_CODE
) (
    input  logic       clk_In,
    input  logic       rst_n,
    input  logic       frame_req_In,
    output logic       rd_en_Out,
    output logic [8:0] rd_addr_Out,
    input  logic [7:0] rd_data_In,
    output logic       TX,
    output logic       busy_Out,
    output logic       frame_done_Out
);

    localparam int c_BIT_MAX = (BREAK_BITS > DMX_SLOT_BITS) ? BREAK_BITS : DMX_SLOT_BITS;
    localparam int c_BIT_W   = $clog2(c_BIT_MAX);

    localparam logic [c_BIT_W-1:0] c_BREAK_LAST = c_BIT_W'(BREAK_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_MAB_LAST   = c_BIT_W'(MAB_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_FIRST = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST  = c_BIT_W'(8);
    localparam logic [c_BIT_W-1:0] c_SLOT_LAST  = c_BIT_W'(DMX_SLOT_BITS - 1);
    localparam logic [9:0]         c_LAST_SLOT  = 10'(NUM_SLOTS);
    localparam logic [7:0]         c_START      = START_CODE;

    dmx_state_t         r_state;
    dmx_state_t         w_state_next;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [9:0]         r_slot_cnt;
    logic               r_req_prev;
    logic [7:0]         r_shift;
    logic               r_rd_en;
    logic               r_rd_en_d;
    logic [8:0]         r_rd_addr;
    logic               r_frame_done;

    logic       w_bit_tick;
    logic       w_req_rise;
    logic       w_break_done;
    logic       w_mab_done;
    logic       w_slot_end;
    logic       w_frame_end;
    logic       w_in_data;
    logic       w_fetch;
    logic [2:0] w_data_idx;
    logic       w_tx;
    logic       w_busy;

    // Only IDLE restarts the divider; every other state change lands on a
    // bit_tick, where the divider wraps to 0 by itself.
    dmx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk_In),
        .rst_n    (rst_n),
        .restart  (r_state == IDLE),
        .bit_tick (w_bit_tick)
    );

    assign w_req_rise   = frame_req_In & ~r_req_prev;
    assign w_break_done = (r_state == BREAK) && w_bit_tick && (r_bit_cnt == c_BREAK_LAST);
    assign w_mab_done   = (r_state == MAB)   && w_bit_tick && (r_bit_cnt == c_MAB_LAST);
    assign w_slot_end   = (r_state == SLOT)  && w_bit_tick && (r_bit_cnt == c_SLOT_LAST);
    assign w_frame_end  = w_slot_end && (r_slot_cnt == c_LAST_SLOT);
    assign w_in_data    = (r_bit_cnt >= c_DATA_FIRST) && (r_bit_cnt <= c_DATA_LAST);
    // bit 1..8 -> data index 0..7 (bit 8 wraps to 7 in three bits)
    assign w_data_idx   = r_bit_cnt[2:0] - 3'd1;

    // Fetch for slot 1 at MAB entry; fetch for slot s+1 (address s) at the
    // start of slot s's first stop bit. Slot 0 is the start code, so it
    // triggers no fetch, and the last slot has nothing after it.
    assign w_fetch = w_break_done ||
                     ((r_state == SLOT) && w_bit_tick && (r_bit_cnt == c_DATA_LAST) &&
                      (r_slot_cnt != 10'd0) && (r_slot_cnt < c_LAST_SLOT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_In) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_req_rise)   w_state_next = BREAK;
            BREAK:   if (w_break_done) w_state_next = MAB;
            MAB:     if (w_mab_done)   w_state_next = SLOT;
            SLOT:    if (w_frame_end)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        case (r_state)
            BREAK: begin
                w_tx   = 1'b0;
                w_busy = 1'b1;
            end
            MAB: begin
                w_busy = 1'b1;
            end
            SLOT: begin
                w_busy = 1'b1;
                if (r_bit_cnt == '0) begin
                    w_tx = 1'b0;
                end else if (w_in_data) begin
                    w_tx = (r_slot_cnt == 10'd0) ? c_START[w_data_idx] : r_shift[0];
                end
            end
            default: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
            end
        endcase
    end

    // ---------------- counters, fetch and shift datapath ----------------
    always_ff @(posedge clk_In) begin
        if (!rst_n) begin
            r_req_prev   <= 1'b1;
            r_bit_cnt    <= '0;
            r_slot_cnt   <= '0;
            r_shift      <= '0;
            r_rd_en      <= 1'b0;
            r_rd_en_d    <= 1'b0;
            r_rd_addr    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_req_prev   <= frame_req_In;
            r_rd_en      <= w_fetch;
            r_rd_en_d    <= r_rd_en;
            r_frame_done <= w_frame_end;

            if ((w_state_next != r_state) || w_slot_end) begin
                r_bit_cnt <= '0;
            end else if (w_bit_tick && (r_state != IDLE)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (r_state != SLOT) begin
                r_slot_cnt <= '0;
            end else if (w_slot_end) begin
                r_slot_cnt <= r_slot_cnt + 10'd1;
            end

            if (w_fetch) begin
                r_rd_addr <= w_break_done ? 9'd0 : r_slot_cnt[8:0];
            end

            // Loads happen during MAB or stop bits, shifts only during data
            // bits of slots 1..N, so the two never collide.
            if (r_rd_en_d) begin
                r_shift <= rd_data_In;
            end else if ((r_state == SLOT) && w_bit_tick && w_in_data && (r_slot_cnt != 10'd0)) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end
        end
    end

    assign TX             = w_tx;
    assign busy_Out       = w_busy;
    assign frame_done_Out = r_frame_done;
    assign rd_en_Out      = r_rd_en;
    assign rd_addr_Out    = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_dmx512_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmx512_tx
//  Purpose  : Directed self-checking bench for dmx512_tx. A small instance
//             (CLKS_PER_BIT=4, NUM_SLOTS=4) is checked cycle by cycle; a
//             default-parameter instance has its BREAK, MAB and bit lengths
//             measured.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmx512_tx;

    logic       clk;
    logic       rst_n;
    logic       frame_req;
    logic       rd_en;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;

    logic       rst2_n;
    logic       req2;
    logic       rd_en2;
    logic [8:0] rd_addr2;
    logic       tx2;
    logic       busy2;
    logic       done2;

    int tests;
    int failed;
    int cyc;
    int rd_n;
    int done_cnt;
    int rd_addr_log [64];
    int rd_cyc_log  [64];
    logic [7:0] mem [4];

    dmx512_tx #(
        .CLKS_PER_BIT (4),
        .NUM_SLOTS    (4)
    ) dut (
        .clk_In         (clk),
        .rst_n          (rst_n),
        .frame_req_In   (frame_req),
        .rd_en_Out      (rd_en),
        .rd_addr_Out    (rd_addr),
        .rd_data_In     (rd_data),
        .TX             (tx),
        .busy_Out       (busy),
        .frame_done_Out (done)
    );

    dmx512_tx dut_def (
        .clk_In         (clk),
        .rst_n          (rst2_n),
        .frame_req_In   (req2),
        .rd_en_Out      (rd_en2),
        .rd_addr_Out    (rd_addr2),
        .rd_data_In     (8'h00),
        .TX             (tx2),
        .busy_Out       (busy2),
        .frame_done_Out (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slot buffer: registered read, filler value when not being read.
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= mem[rd_addr[1:0]];
        else                rd_data <= 8'h3C;
    end

    always @(negedge clk) begin
        if (rd_en === 1'b1 && rd_n < 64) begin
            rd_addr_log[rd_n] = 32'(rd_addr);
            rd_cyc_log[rd_n]  = cyc;
            rd_n++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected TX c cycles after the frame-start edge (default BREAK/MAB,
    // 4 clocks per bit, slots 00,A5,01,80,FF).
    function automatic logic exp_tx(input int c);
        int k, s, b;
        logic [7:0] d;
        if (c < 100) return 1'b0;
        if (c < 112) return 1'b1;
        k = (c - 112) / 4;
        s = k / 11;
        b = k % 11;
        if (s > 4) return 1'b1;
        d = (s == 0) ? 8'h00 : mem[s-1];
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Leaves the bench at the negedge just before the frame-start edge.
    task automatic start_frame();
        @(negedge clk); frame_req = 1'b0;
        @(negedge clk); frame_req = 1'b1;
    endtask

    task automatic check_frame(input bit glitch);
        int base_rd, base_done, start_cyc;
        int exp_cyc [4];
        exp_cyc = '{100, 192, 236, 280};
        base_rd   = rd_n;
        base_done = done_cnt;
        start_cyc = 0;
        start_frame();
        for (int c = 0; c <= 333; c++) begin
            @(negedge clk);
            if (c == 0) start_cyc = cyc;
            check($sformatf("tx[c=%0d]", c), 32'(tx), 32'(exp_tx(c)));
            check($sformatf("busy[c=%0d]", c), 32'(busy), (c < 332) ? 32'd1 : 32'd0);
            check($sformatf("done[c=%0d]", c), 32'(done), (c == 332) ? 32'd1 : 32'd0);
            if (glitch && c == 150) frame_req = 1'b0;
            if (glitch && c == 210) frame_req = 1'b1;
        end
        check("rd_pulse_count", 32'(rd_n - base_rd), 32'd4);
        check("done_pulse_count", 32'(done_cnt - base_done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (base_rd + i < rd_n) begin
                check($sformatf("rd_addr[%0d]", i), 32'(rd_addr_log[base_rd+i]), 32'(i));
                check($sformatf("rd_cycle[%0d]", i), 32'(rd_cyc_log[base_rd+i] - start_cyc), 32'(exp_cyc[i]));
            end
        end
    endtask

    task automatic abort_at(input int when, input string tag);
        start_frame();
        for (int c = 0; c <= when; c++) @(negedge clk);
        check({tag, "_busy_before"}, 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check({tag, "_tx"}, 32'(tx), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic measure_run(input logic level, input int exp_len, input string tag);
        int n;
        n = 0;
        while (tx2 === level && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp_len));
    endtask

    initial begin
        int base_done;
        tests = 0; failed = 0; cyc = 0; rd_n = 0; done_cnt = 0;
        mem[0] = 8'hA5; mem[1] = 8'h01; mem[2] = 8'h80; mem[3] = 8'hFF;
        rst_n = 1'b0; frame_req = 1'b1;
        rst2_n = 1'b0; req2 = 1'b0;

        // Reset values, request held high through reset.
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("idle_tx[%0d]", i), 32'(tx), 32'd1);
            check($sformatf("idle_busy[%0d]", i), 32'(busy), 32'd0);
        end

        // Full frame with a second request edge in mid-slot 2.
        check_frame(1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check($sformatf("no_requeue_busy[%0d]", i), 32'(busy), 32'd0);
        end

        // Reset during BREAK, then during slot 3.
        base_done = done_cnt;
        abort_at(50, "abort_break");
        for (int i = 0; i < 30; i++) @(negedge clk);
        check("abort_break_stays_idle", 32'(busy), 32'd0);
        abort_at(260, "abort_slot3");
        for (int i = 0; i < 400; i++) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Clean frame after the aborts.
        check_frame(1'b0);

        // Default parameters: BREAK 1200, MAB 144, start bit + 8 zero data
        // bits of start code 00 = 432, two stop bits = 96.
        @(negedge clk); req2 = 1'b0;
        @(negedge clk); req2 = 1'b1;
        @(negedge clk);
        check("def_busy", 32'(busy2), 32'd1);
        measure_run(1'b0, 1200, "def_break_len");
        measure_run(1'b1, 144, "def_mab_len");
        measure_run(1'b0, 432, "def_slot0_low_len");
        measure_run(1'b1, 96, "def_stop_len");
        rst2_n = 1'b0;
        @(negedge clk);
        check("def_abort_tx", 32'(tx2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
